redirect_ctrl: RTL and testbench
================================

# redirect_ctrl

Control-transfer sequencer between the decode-stage branch unit and the instruction fetch unit. It takes each resolved branch/jump from decode and turns a taken result into a redirect handshake to IFU. It flushes the IF/ID register and kills stale fetch responses until the first instruction from the new target arrives. It stalls decode while a redirect is in flight, traps misaligned targets, and keeps branch/taken statistics counters.

## Interface
Parameters:
- RESET_PC, 32'h8000_0000, value of redirect_pc_o after reset
- CNT_W, 32, width of statistics counters

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-low; state clears immediately while 0
- id_valid_i  input  1  decode presents a resolved control-transfer instruction
- id_ready_o  output  1  controller accepts it; handshake = id_valid_i & id_ready_o
- branch_en_i  input  1  branch unit: transfer taken
- dnpc_i  input  32  branch unit: target address
- redirect_valid_o  output  1  redirect request to IFU
- redirect_pc_o  output  32  redirect target; stable while redirect_valid_o=1
- redirect_ready_i  input  1  IFU accepts redirect
- flush_o  output  1  one-cycle pulse: invalidate IF/ID pipeline register
- if_valid_i  input  1  IFU delivers a fetched instruction
- if_pc_i  input  32  PC of the delivered instruction
- kill_o  output  1  combinational: discard current IFU delivery
- misalign_o  output  1  one-cycle pulse: taken target with dnpc_i[1:0] != 0
- branch_cnt_o  output  CNT_W  accepted control transfers
- taken_cnt_o  output  CNT_W  accepted taken transfers with aligned target

## Operation
- States: IDLE, WAIT_ACK, DRAIN. Reset state is IDLE.
- id_ready_o = 1 only in IDLE.
- IDLE, handshake, branch_en_i=0:
  - branch_cnt +1
  - stay in IDLE
- IDLE, handshake, branch_en_i=1, dnpc_i[1:0]!=0:
  - branch_cnt +1
  - misalign_o pulses on the next cycle
  - no redirect; stay in IDLE
- IDLE, handshake, branch_en_i=1, aligned target:
  - branch_cnt +1, taken_cnt +1
  - latch dnpc_i into redirect_pc_o
  - next cycle: redirect_valid_o=1, flush_o=1 (one cycle only)
  - go to WAIT_ACK
- WAIT_ACK:
  - hold redirect_valid_o=1 and redirect_pc_o until redirect_ready_i=1
  - on acceptance: redirect_valid_o=0 the next cycle; go to DRAIN
  - kill_o = if_valid_i (every delivery is stale)
- DRAIN:
  - kill_o = if_valid_i & (if_pc_i != redirect_pc_o)
  - if_valid_i with if_pc_i == redirect_pc_o: kill_o=0, instruction passes, go to IDLE
- IDLE: kill_o=0.
- Counters are unsigned and wrap modulo 2^CNT_W without saturation.
- flush_o and misalign_o are registered single-cycle pulses.

## Timing
- Reset values:
  - state IDLE, id_ready_o 1, redirect_valid_o 0, redirect_pc_o RESET_PC
  - flush_o 0, misalign_o 0, counters 0
- Handshake at edge T: redirect_valid_o and flush_o high in cycle T+1; counters updated in T+1.
- redirect_ready_i high in the first redirect_valid_o cycle: accepted that cycle; DRAIN from the next cycle. Minimum redirect turnaround is 1 cycle.
- The cycle after acceptance, redirect_valid_o is low and state is DRAIN.
- Matching delivery in DRAIN at edge D: id_ready_o=1 from D+1.
- If the IFU delivers a matching PC in the same cycle as acceptance, it is still killed (state is WAIT_ACK). Only DRAIN-state matches end the drain.
- A second taken branch cannot arrive before IDLE, because id_ready_o=0.
- Asynchronous rst low mid-redirect: all outputs take reset values immediately. A pending redirect is dropped and no flush pulse is issued.
- Counter wrap: all-ones + 1 gives 0 with no side effects.

## Test plan
- Reset: hold rst=0 → redirect_pc_o=32'h8000_0000, id_ready_o=1, all other outputs 0.
- Not-taken branch, id_valid_i=1, branch_en_i=0 → branch_cnt_o=1, taken_cnt_o=0, no redirect, id_ready_o stays 1.
- Taken to 32'h8000_0100 with redirect_ready_i tied 1 → redirect_valid_o and flush_o high exactly one cycle. Deliveries of PCs 0x8000_0008 and 0x8000_000C are killed; delivery of 0x8000_0100 passes; IDLE one cycle later.
- Taken with redirect_ready_i low for 3 cycles → redirect_valid_o high 4 cycles, pc stable, flush_o high only the first cycle, id_ready_o low throughout.
- dnpc_i=32'h8000_0102, taken → misalign_o one-cycle pulse, no redirect_valid_o, taken_cnt_o unchanged, branch_cnt_o +1.
- rst pulsed low during WAIT_ACK → outputs return to reset values asynchronously; after release, a new branch is accepted normally. Separately, force branch_cnt to all-ones: next branch wraps it to 0.

Source files
------------

// File: rtl/redirect_ctrl.sv
`default_nettype none
// ============================================================================
// redirect_ctrl : turns taken decode-stage branches into IFU redirects,
//                 flushes IF/ID, kills stale fetches, and counts branches.
// Revision 1.0
// ============================================================================
module redirect_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid_i,
    output logic             id_ready_o,
    input  logic             branch_en_i,
    input  logic [31:0]      dnpc_i,
    output logic             redirect_valid_o,
    output logic [31:0]      redirect_pc_o,
    input  logic             redirect_ready_i,
    output logic             flush_o,
    input  logic             if_valid_i,
    input  logic [31:0]      if_pc_i,
    output logic             kill_o,
    output logic             misalign_o,
    output logic [CNT_W-1:0] branch_cnt_o,
    output logic [CNT_W-1:0] taken_cnt_o
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_ACK = 2'd1,
        S_DRAIN    = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    logic             r_id_ready;
    logic             r_redirect_valid;
    logic [31:0]      r_redirect_pc;
    logic             r_flush;
    logic             r_misalign;
    logic [CNT_W-1:0] r_branch_cnt;
    logic [CNT_W-1:0] r_taken_cnt;

    logic w_handshake;
    logic w_aligned;
    logic w_target_hit;

    assign w_handshake  = id_valid_i & r_id_ready;
    assign w_aligned    = (dnpc_i[1:0] == 2'b00);
    assign w_target_hit = if_valid_i & (if_pc_i == r_redirect_pc);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state          <= S_IDLE;
            r_id_ready       <= 1'b1;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= RESET_PC;
            r_flush          <= 1'b0;
            r_misalign       <= 1'b0;
            r_branch_cnt     <= '0;
            r_taken_cnt      <= '0;
        end else begin
            r_flush    <= 1'b0;
            r_misalign <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_handshake) begin
                        r_branch_cnt <= r_branch_cnt + C_CNT_ONE;
                        if (branch_en_i && !w_aligned) begin
                            r_misalign <= 1'b1;
                        end else if (branch_en_i) begin
                            r_taken_cnt      <= r_taken_cnt + C_CNT_ONE;
                            r_redirect_pc    <= dnpc_i;
                            r_redirect_valid <= 1'b1;
                            r_flush          <= 1'b1;
                            r_id_ready       <= 1'b0;
                            r_state          <= S_WAIT_ACK;
                        end
                    end
                end
                S_WAIT_ACK: begin
                    if (redirect_ready_i) begin
                        r_redirect_valid <= 1'b0;
                        r_state          <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // Only a delivery from the new target ends the drain.
                    if (w_target_hit) begin
                        r_id_ready <= 1'b1;
                        r_state    <= S_IDLE;
                    end
                end
                default: begin
                    r_state          <= S_IDLE;
                    r_id_ready       <= 1'b1;
                    r_redirect_valid <= 1'b0;
                end
            endcase
        end
    end

    // While waiting for the IFU ack every delivery is stale, even a matching one.
    always_comb begin
        kill_o = 1'b0;
        case (r_state)
            S_WAIT_ACK: kill_o = if_valid_i;
            S_DRAIN:    kill_o = if_valid_i & ~w_target_hit;
            default:    kill_o = 1'b0;
        endcase
    end

    assign id_ready_o       = r_id_ready;
    assign redirect_valid_o = r_redirect_valid;
    assign redirect_pc_o    = r_redirect_pc;
    assign flush_o          = r_flush;
    assign misalign_o       = r_misalign;
    assign branch_cnt_o     = r_branch_cnt;
    assign taken_cnt_o      = r_taken_cnt;

endmodule
`default_nettype wire

// File: tb/tb_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// tb_redirect_ctrl : scoreboard bench for redirect_ctrl with a
//                    transaction-level reference model.
// Revision 1.0
// ============================================================================
module tb_redirect_ctrl;

    localparam int          CW  = 4;
    localparam logic [31:0] RPC = 32'h8000_0000;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid_i;
    logic          id_ready_o;
    logic          branch_en_i;
    logic [31:0]   dnpc_i;
    logic          redirect_valid_o;
    logic [31:0]   redirect_pc_o;
    logic          redirect_ready_i;
    logic          flush_o;
    logic          if_valid_i;
    logic [31:0]   if_pc_i;
    logic          kill_o;
    logic          misalign_o;
    logic [CW-1:0] branch_cnt_o;
    logic [CW-1:0] taken_cnt_o;

    redirect_ctrl #(.RESET_PC(RPC), .CNT_W(CW)) dut (
        .clk              (clk),
        .rst              (rst),
        .id_valid_i       (id_valid_i),
        .id_ready_o       (id_ready_o),
        .branch_en_i      (branch_en_i),
        .dnpc_i           (dnpc_i),
        .redirect_valid_o (redirect_valid_o),
        .redirect_pc_o    (redirect_pc_o),
        .redirect_ready_i (redirect_ready_i),
        .flush_o          (flush_o),
        .if_valid_i       (if_valid_i),
        .if_pc_i          (if_pc_i),
        .kill_o           (kill_o),
        .misalign_o       (misalign_o),
        .branch_cnt_o     (branch_cnt_o),
        .taken_cnt_o      (taken_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          ready;
        logic          rvalid;
        logic [31:0]   rpc;
        logic          flush;
        logic          mis;
        logic          kill;
        logic [CW-1:0] bcnt;
        logic [CW-1:0] tcnt;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;
    bit   mon_en = 1'b0;

    // Reference model: a redirect is either absent, awaiting IFU ack, or acked
    // and waiting for its target to show up on the fetch side.
    bit          m_busy;
    bit          m_acked;
    bit          m_flush;
    bit          m_mis;
    logic [31:0] m_target;
    int          m_branches;
    int          m_taken;

    task automatic model_reset();
        m_busy     = 1'b0;
        m_acked    = 1'b0;
        m_flush    = 1'b0;
        m_mis      = 1'b0;
        m_target   = RPC;
        m_branches = 0;
        m_taken    = 0;
    endtask

    task automatic drive(input logic r, input logic iv, input logic be,
                         input logic [31:0] dn, input logic rr,
                         input logic fv, input logic [31:0] fp);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; id_valid_i = iv; branch_en_i = be; dnpc_i = dn;
        redirect_ready_i = rr; if_valid_i = fv; if_pc_i = fp;
        #1;
        if (!r) model_reset();
        e.ready  = !m_busy;
        e.rvalid = m_busy && !m_acked;
        e.rpc    = m_target;
        e.flush  = m_flush;
        e.mis    = m_mis;
        e.kill   = m_busy && fv && (!m_acked || fp != m_target);
        e.bcnt   = CW'(m_branches);
        e.tcnt   = CW'(m_taken);
        sb_q.push_back(e);
        mon_en = 1'b1;
        if (r) begin
            m_flush = 1'b0;
            m_mis   = 1'b0;
            if (!m_busy && iv) begin
                m_branches++;
                if (be && dn[1:0] != 2'b00) begin
                    m_mis = 1'b1;
                end else if (be) begin
                    m_taken++;
                    m_target = dn;
                    m_busy   = 1'b1;
                    m_acked  = 1'b0;
                    m_flush  = 1'b1;
                end
            end else if (m_busy && !m_acked && rr) begin
                m_acked = 1'b1;
            end else if (m_busy && m_acked && fv && fp == m_target) begin
                m_busy = 1'b0;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (mon_en) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_empty: got 0 entries expected 1 at %0t", $time);
            end else begin
                e = sb_q.pop_front();
                chk("id_ready",       32'(id_ready_o),       32'(e.ready));
                chk("redirect_valid", 32'(redirect_valid_o), 32'(e.rvalid));
                chk("redirect_pc",    redirect_pc_o,         e.rpc);
                chk("flush",          32'(flush_o),          32'(e.flush));
                chk("misalign",       32'(misalign_o),       32'(e.mis));
                chk("kill",           32'(kill_o),           32'(e.kill));
                chk("branch_cnt",     32'(branch_cnt_o),     32'(e.bcnt));
                chk("taken_cnt",      32'(taken_cnt_o),      32'(e.tcnt));
            end
        end
    end

    initial begin
        logic [31:0] dn;
        logic [31:0] fp;
        rst = 1'b0; id_valid_i = 1'b0; branch_en_i = 1'b0; dnpc_i = '0;
        redirect_ready_i = 1'b0; if_valid_i = 1'b0; if_pc_i = '0;
        model_reset();

        repeat (3) drive(0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);

        // Not-taken branch
        drive(1, 1, 0, 32'h8000_0040, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);

        // Taken, IFU ready immediately; stale deliveries then the target
        drive(1, 1, 1, 32'h8000_0100, 1, 0, 0);
        drive(1, 0, 0, 0, 1, 1, 32'h8000_0008);
        drive(1, 0, 0, 0, 1, 1, 32'h8000_000C);
        drive(1, 0, 0, 0, 1, 1, 32'h8000_0100);
        drive(1, 0, 0, 0, 0, 0, 0);

        // Taken, IFU back-pressures 3 cycles; matching PC during WAIT_ACK is killed
        drive(1, 1, 1, 32'h8000_0200, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 1, 32'h8000_0200);
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 1, 1, 32'h8000_0200);
        drive(1, 0, 0, 0, 0, 1, 32'h8000_0200);
        drive(1, 0, 0, 0, 0, 0, 0);

        // Misaligned taken target
        drive(1, 1, 1, 32'h8000_0102, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);

        // Asynchronous reset while waiting for the ack
        drive(1, 1, 1, 32'h8000_0300, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 1, 32'h8000_0010);
        drive(0, 1, 1, 32'h8000_0400, 1, 1, 32'h8000_0300);
        drive(1, 1, 0, 32'h8000_0500, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);

        // Counter wrap
        for (int i = 0; i < 18; i++) drive(1, 1, 0, 32'h8000_0600, 0, 0, 0);
        drive(1, 1, 1, 32'h8000_0700, 1, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 1, 32'h8000_0700);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            dn = {$urandom_range(32'h0000_FFFF, 0), 2'b00};
            dn[31] = 1'b1;
            if ($urandom_range(4, 0) == 0) dn[1:0] = 2'($urandom_range(3, 1));
            fp = ($urandom_range(2, 0) == 0) ? m_target : {$urandom_range(32'h0000_FFFF, 0), 2'b00};
            drive(($urandom_range(63, 0) != 0),
                  1'($urandom_range(1, 0)),
                  1'($urandom_range(1, 0)),
                  dn,
                  1'($urandom_range(1, 0)),
                  1'($urandom_range(1, 0)),
                  fp);
        end

        drive(1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        mon_en = 1'b0;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
